// File: rtl/fifo_8x32_if.sv
// Handshake and data bundle between the 8x32 FIFO and the logic around it.
// The master side issues requests; the slave side is the FIFO.
interface fifo_8x32_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  full;
    logic                  empty;
    logic                  wr_ack;
    logic                  wr_err;
    logic                  rd_ack;
    logic                  rd_err;
    logic [3:0]            data_count;

    modport master (
        output wr_en, rd_en, d_in,
        input  d_out, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count
    );

    modport slave (
        input  wr_en, rd_en, d_in,
        output d_out, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count
    );
endinterface

// File: rtl/fifo_8x32.sv
// 8-entry x 32-bit synchronous FIFO with registered read data and a state register
// whose value directly decodes into one-cycle ack/err pulses.
module fifo_8x32 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic         clk,
    input  logic         reset,
    fifo_8x32_if.slave   bus_io
);
    localparam logic [2:0] StInit    = 3'd0;
    localparam logic [2:0] StNoOp    = 3'd1;
    localparam logic [2:0] StWrite   = 3'd2;
    localparam logic [2:0] StWrError = 3'd3;
    localparam logic [2:0] StRead    = 3'd4;
    localparam logic [2:0] StRdError = 3'd5;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [2:0]            head_q, head_d;
    logic [2:0]            tail_q, tail_d;
    logic [3:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [2:0]            state_q, state_d;
    logic                  mem_we;
    logic                  full;
    logic                  empty;

    assign full  = (count_q == 4'(DEPTH));
    assign empty = (count_q == 4'd0);

    // Simultaneous read and write requests fall through to NO_OP.
    always_comb begin
        state_d = StNoOp;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dout_d  = dout_q;
        mem_we  = 1'b0;
        if (bus_io.wr_en && !bus_io.rd_en) begin
            if (full) begin
                state_d = StWrError;
            end else begin
                state_d = StWrite;
                tail_d  = tail_q + 3'd1;
                count_d = count_q + 4'd1;
                mem_we  = 1'b1;
            end
        end else if (bus_io.rd_en && !bus_io.wr_en) begin
            if (empty) begin
                state_d = StRdError;
            end else begin
                state_d = StRead;
                head_d  = head_q + 3'd1;
                count_d = count_q - 4'd1;
                dout_d  = mem_q[head_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            head_q  <= 3'd0;
            tail_q  <= 3'd0;
            count_q <= 4'd0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    // Storage is deliberately left uncleared by reset; the pointers discard it.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[tail_q] <= bus_io.d_in;
        end
    end

    assign bus_io.d_out      = dout_q;
    assign bus_io.full       = full;
    assign bus_io.empty      = empty;
    assign bus_io.data_count = count_q;
    assign bus_io.wr_ack     = (state_q == StWrite);
    assign bus_io.wr_err     = (state_q == StWrError);
    assign bus_io.rd_ack     = (state_q == StRead);
    assign bus_io.rd_err     = (state_q == StRdError);
endmodule

// File: tb/tb_fifo_8x32.sv
// Directed testbench for fifo_8x32: reset, ordering, full/empty errors,
// simultaneous requests, pointer wrap and reset mid-sequence.
module tb_fifo_8x32;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    fifo_8x32_if #(.DATA_WIDTH(32)) bus ();

    fifo_8x32 #(.DATA_WIDTH(32), .DEPTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    logic [3:0] flags;
    assign flags = {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b0;
        bus.d_in  = 32'hDEAD_BEEF;
        step();
        step();
        n_cmp++;
        if (bus.data_count !== 4'd0) begin
            n_err++; $display("FAIL reset_count got=%0d want=0", bus.data_count);
        end
        n_cmp++;
        if ({bus.empty, bus.full} !== 2'b10) begin
            n_err++; $display("FAIL reset_empty_full got=%b want=10", {bus.empty, bus.full});
        end
        n_cmp++;
        if (bus.d_out !== 32'h0) begin
            n_err++; $display("FAIL reset_dout got=%h want=0", bus.d_out);
        end
        n_cmp++;
        if (flags !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got=%b want=0000", flags);
        end
        reset = 1'b0;
        idle();
        step();
        n_cmp++;
        if ({bus.empty, bus.data_count} !== {1'b1, 4'd0}) begin
            n_err++; $display("FAIL reset_no_write got=%b/%0d want=1/0", bus.empty, bus.data_count);
        end
    endtask

    task automatic test_basic_order();
        logic [31:0] vals [3] = '{32'hA, 32'hB, 32'hC};
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1;
            bus.d_in  = vals[i];
            step();
            n_cmp++;
            if ({flags, bus.data_count} !== {4'b1000, 4'(i + 1)}) begin
                n_err++;
                $display("FAIL basic_wr%0d got=%b/%0d want=1000/%0d", i, flags, bus.data_count,
                         i + 1);
            end
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            bus.rd_en = 1'b1;
            step();
            n_cmp++;
            if ({flags, bus.d_out} !== {4'b0010, vals[i]}) begin
                n_err++;
                $display("FAIL basic_rd%0d got=%b/%h want=0010/%h", i, flags, bus.d_out, vals[i]);
            end
        end
        idle();
        step();
        n_cmp++;
        if ({bus.empty, flags} !== {1'b1, 4'b0000}) begin
            n_err++; $display("FAIL basic_empty got=%b/%b want=1/0000", bus.empty, flags);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1'b1;
            bus.d_in  = 32'h10 + 32'(i);
            step();
        end
        n_cmp++;
        if ({bus.full, bus.data_count} !== {1'b1, 4'd8}) begin
            n_err++; $display("FAIL full_flag got=%b/%0d want=1/8", bus.full, bus.data_count);
        end
        bus.d_in = 32'hFF;
        step();
        n_cmp++;
        if ({flags, bus.data_count} !== {4'b0100, 4'd8}) begin
            n_err++; $display("FAIL full_wr_err got=%b/%0d want=0100/8", flags, bus.data_count);
        end
        idle();
        step();
        n_cmp++;
        if (flags !== 4'b0000) begin
            n_err++; $display("FAIL full_err_pulse got=%b want=0000", flags);
        end
        for (int i = 0; i < 8; i++) begin
            bus.rd_en = 1'b1;
            step();
            n_cmp++;
            if ({flags, bus.d_out} !== {4'b0010, 32'h10 + 32'(i)}) begin
                n_err++;
                $display("FAIL full_drain%0d got=%b/%h want=0010/%h", i, flags, bus.d_out,
                         32'h10 + 32'(i));
            end
        end
        idle();
        n_cmp++;
        if (bus.data_count !== 4'd0) begin
            n_err++; $display("FAIL full_drained got=%0d want=0", bus.data_count);
        end
    endtask

    task automatic test_empty();
        bus.rd_en = 1'b1;
        step();
        idle();
        n_cmp++;
        if ({flags, bus.d_out, bus.data_count, bus.empty} !== {4'b0001, 32'h17, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL empty_rd_err got=%b/%h/%0d want=0001/17/0", flags, bus.d_out,
                     bus.data_count);
        end
        step();
        n_cmp++;
        if ({flags, bus.d_out} !== {4'b0000, 32'h17}) begin
            n_err++; $display("FAIL empty_hold got=%b/%h want=0000/17", flags, bus.d_out);
        end
    endtask

    task automatic test_simultaneous();
        bus.wr_en = 1'b1;
        bus.d_in  = 32'h21;
        step();
        bus.d_in  = 32'h22;
        step();
        bus.rd_en = 1'b1;
        bus.d_in  = 32'h99;
        step();
        idle();
        n_cmp++;
        if ({flags, bus.data_count, bus.d_out} !== {4'b0000, 4'd2, 32'h17}) begin
            n_err++;
            $display("FAIL simul_noop got=%b/%0d/%h want=0000/2/17", flags, bus.data_count,
                     bus.d_out);
        end
        bus.rd_en = 1'b1;
        step();
        n_cmp++;
        if (bus.d_out !== 32'h21) begin
            n_err++; $display("FAIL simul_rd0 got=%h want=21", bus.d_out);
        end
        step();
        n_cmp++;
        if ({bus.d_out, bus.data_count} !== {32'h22, 4'd0}) begin
            n_err++; $display("FAIL simul_rd1 got=%h/%0d want=22/0", bus.d_out, bus.data_count);
        end
        idle();
    endtask

    task automatic test_wrap();
        logic [31:0] tail_exp [8] = '{32'h105, 32'h106, 32'h107, 32'h200,
                                      32'h201, 32'h202, 32'h203, 32'h204};
        bus.wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.d_in = 32'h100 + 32'(i);
            step();
        end
        idle();
        bus.rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (bus.d_out !== 32'h100 + 32'(i)) begin
                n_err++; $display("FAIL wrap_rdA%0d got=%h want=%h", i, bus.d_out,
                                  32'h100 + 32'(i));
            end
        end
        idle();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.d_in = 32'h200 + 32'(i);
            step();
        end
        idle();
        n_cmp++;
        if ({bus.full, bus.data_count} !== {1'b1, 4'd8}) begin
            n_err++; $display("FAIL wrap_refill got=%b/%0d want=1/8", bus.full, bus.data_count);
        end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if ({flags, bus.d_out} !== {4'b0010, tail_exp[i]}) begin
                n_err++; $display("FAIL wrap_rdB%0d got=%b/%h want=0010/%h", i, flags, bus.d_out,
                                  tail_exp[i]);
            end
        end
        idle();
        n_cmp++;
        if ({bus.empty, bus.data_count} !== {1'b1, 4'd0}) begin
            n_err++; $display("FAIL wrap_final got=%b/%0d want=1/0", bus.empty, bus.data_count);
        end
    endtask

    task automatic test_reset_mid();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.d_in = 32'h300 + 32'(i);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        n_cmp++;
        if ({bus.empty, bus.data_count, bus.d_out} !== {1'b1, 4'd0, 32'h0}) begin
            n_err++;
            $display("FAIL mid_reset got=%b/%0d/%h want=1/0/0", bus.empty, bus.data_count,
                     bus.d_out);
        end
        bus.rd_en = 1'b1;
        step();
        idle();
        n_cmp++;
        if (flags !== 4'b0001) begin
            n_err++; $display("FAIL mid_reset_rd got=%b want=0001", flags);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.d_in  = '0;
        test_reset();
        test_basic_order();
        test_full();
        test_empty();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
